// File: rtl/frame_scan_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : frame_scan_pkg
// Brief    : Shared types and defaults for the frame scan sequencer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package frame_scan_pkg;

    localparam int c_DEFAULT_WIDTH  = 640;
    localparam int c_DEFAULT_HEIGHT = 480;
    // Write-address field carried through the delay line; sized for the default frame.
    localparam int c_PIPE_ADDR_W    = 19;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic                     valid;
        logic [c_PIPE_ADDR_W-1:0] addr;
        logic [9:0]               x;
        logic [8:0]               y;
    } pipe_entry_t;

endpackage
`default_nettype wire

// File: rtl/scan_delay_line.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : scan_delay_line
// Brief    : LAT-deep valid/data shift register with asynchronous clear.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module scan_delay_line
    import frame_scan_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pipe_entry_t i_entry,
    output pipe_entry_t o_entry,
    output logic        o_busy
);

    logic [LAT-1:0] r_valid;
    pipe_entry_t    r_data [LAT];
    logic [LAT-1:0] w_in_valid;
    pipe_entry_t    w_in_data [LAT];

    generate
        for (genvar k = 0; k < LAT; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_in_valid[k] = i_entry.valid;
                assign w_in_data[k]  = i_entry;
            end else begin : g_tail
                assign w_in_valid[k] = r_valid[k-1];
                assign w_in_data[k]  = r_data[k-1];
            end
        end
    endgenerate

    // Payload only loads behind a valid beat so the tail holds the last written pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LAT; k++) begin
                r_valid[k] <= w_in_valid[k];
                if (w_in_valid[k]) begin
                    r_data[k] <= w_in_data[k];
                end
            end
        end
    end

    always_comb begin
        o_entry       = r_data[LAT-1];
        o_entry.valid = r_valid[LAT-1];
    end

    assign o_busy = |r_valid;

endmodule
`default_nettype wire

// File: rtl/frame_scan_sequencer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : frame_scan_sequencer
// Brief    : Raster read sequencer with delay-matched write side for one frame.
//            Optional FRAME_SCAN_DECIMATE_EN adds 2:1 decimation (decim port).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module frame_scan_sequencer
    import frame_scan_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int HEIGHT = c_DEFAULT_HEIGHT,
    parameter int ADDR_W = 19,
    parameter int LAT    = 3
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
`ifdef FRAME_SCAN_DECIMATE_EN
    input  logic              decim,
`endif
    output logic [ADDR_W-1:0] addr_mem0,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr_mem1,
    output logic              we,
    output logic [9:0]        pix_x,
    output logic [8:0]        pix_y,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [9:0] c_X_LAST = 10'(WIDTH - 1);
    localparam logic [8:0] c_Y_LAST = 9'(HEIGHT - 1);

    scan_state_t       r_state;
    scan_state_t       w_state_next;
    logic              r_pending;
    logic              w_pending_next;
    logic              w_enter_scan;
    logic              w_busy;
    logic              w_done;
    logic              w_step;
    logic              w_last;
    logic              w_issue;
    logic              w_pix_sel;
    logic              w_pipe_busy;
    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [9:0]        w_wr_x;
    logic [8:0]        w_wr_y;
    pipe_entry_t       w_pipe_in;
    pipe_entry_t       w_pipe_out;

    assign w_step  = (r_state == SCAN) && !pause;
    assign w_last  = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_issue = w_step && w_pix_sel;

    always_comb begin
        w_state_next   = r_state;
        w_pending_next = r_pending;
        w_enter_scan   = 1'b0;
        w_busy         = 1'b0;
        w_done         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start || r_pending) begin
                    w_state_next   = SCAN;
                    w_pending_next = 1'b0;
                    w_enter_scan   = 1'b1;
                end
            end
            SCAN: begin
                w_busy = 1'b1;
                if (start) w_pending_next = 1'b1;
                if (w_step && w_last) w_state_next = DRAIN;
            end
            DRAIN: begin
                if (w_pipe_busy) begin
                    w_busy = 1'b1;
                    if (start) w_pending_next = 1'b1;
                end else begin
                    // A start landing on the done cycle becomes the next pending frame.
                    w_done         = 1'b1;
                    w_pending_next = start;
                    if (r_pending) begin
                        w_state_next = SCAN;
                        w_enter_scan = 1'b1;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pending <= w_pending_next;
        end
    end

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if ((r_state != SCAN) || (w_step && w_last)) begin
            r_x    <= '0;
            r_y    <= '0;
            r_addr <= '0;
        end else if (w_step) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_x == c_X_LAST) begin
                r_x <= '0;
                r_y <= r_y + 9'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

`ifdef FRAME_SCAN_DECIMATE_EN
    logic              r_decim;
    logic [ADDR_W-1:0] r_dec_addr;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            r_decim    <= 1'b0;
            r_dec_addr <= '0;
        end else begin
            if (w_enter_scan) r_decim <= decim;
            if (r_state != SCAN) begin
                r_dec_addr <= '0;
            end else if (w_issue) begin
                r_dec_addr <= r_dec_addr + ADDR_W'(1);
            end
        end
    end

    // Decimated frames are written densely at half resolution.
    assign w_pix_sel = !r_decim || !(r_x[0] || r_y[0]);
    assign w_wr_addr = r_decim ? r_dec_addr : r_addr;
    assign w_wr_x    = r_decim ? {1'b0, r_x[9:1]} : r_x;
    assign w_wr_y    = r_decim ? {1'b0, r_y[8:1]} : r_y;
`else
    assign w_pix_sel = 1'b1;
    assign w_wr_addr = r_addr;
    assign w_wr_x    = r_x;
    assign w_wr_y    = r_y;
`endif

    always_comb begin
        w_pipe_in       = '0;
        w_pipe_in.valid = w_issue;
        w_pipe_in.addr  = c_PIPE_ADDR_W'(w_wr_addr);
        w_pipe_in.x     = w_wr_x;
        w_pipe_in.y     = w_wr_y;
    end

    scan_delay_line #(
        .LAT (LAT)
    ) u_delay (
        .clk     (clk25),
        .rst_n   (rst_n),
        .i_entry (w_pipe_in),
        .o_entry (w_pipe_out),
        .o_busy  (w_pipe_busy)
    );

    assign addr_mem0  = r_addr;
    assign rd_en      = w_issue;
    assign we         = w_pipe_out.valid;
    assign addr_mem1  = ADDR_W'(w_pipe_out.addr);
    assign pix_x      = w_pipe_out.x;
    assign pix_y      = w_pipe_out.y;
    assign busy       = w_busy;
    assign frame_done = w_done;

endmodule
`default_nettype wire
